sr_mul_scheduler: RTL and testbench

SR_MUL_SCHEDULER -- requirements
Module: sr_mul_scheduler

---
 rtl/sr_mul_scheduler.sv | 80 ++++++++
 tb/tb_sr_mul_scheduler.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sr_mul_scheduler.sv
`default_nettype none
// ============================================================================
// Module : sr_mul_scheduler
// Brief  : Scoreboard/issue control for a fixed-latency pipelined multiplier.
// Rev    : 1.0  initial release
// ============================================================================
module sr_mul_scheduler #(
    parameter int N = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dec_valid,
    input  logic       dec_is_mul,
    input  logic       dec_wr,
    input  logic [4:0] dec_rs1,
    input  logic [4:0] dec_rs2,
    input  logic [4:0] dec_rd,
    input  logic [1:0] dec_rs_used,
    output logic       stall,
    output logic       mul_start,
    output logic       wb_valid,
    output logic [4:0] wb_rd,
    output logic [4:0] inflight
);

    logic [N-1:0] valid_q, valid_d;
    logic [4:0]   rd_q [N];
    logic [4:0]   rd_d [N];
    logic [4:0]   inflight_q, inflight_d;
    logic         raw, waw, wbc;

    assign wb_valid = valid_q[N-1];
    assign wb_rd    = rd_q[N-1];
    assign inflight = inflight_q;

    // Every valid stage, including the one writing back this cycle, still
    // blocks readers and writers of its rd: there is no bypass path.
    always_comb begin
        raw = 1'b0;
        waw = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (valid_q[i]) begin
                if (dec_rs_used[0] && (dec_rs1 != 5'd0) && (dec_rs1 == rd_q[i])) raw = 1'b1;
                if (dec_rs_used[1] && (dec_rs2 != 5'd0) && (dec_rs2 == rd_q[i])) raw = 1'b1;
                if (dec_wr && (dec_rd != 5'd0) && (dec_rd == rd_q[i]))           waw = 1'b1;
            end
        end
        wbc       = dec_wr & ~dec_is_mul & wb_valid;
        stall     = dec_valid & (raw | waw | wbc);
        mul_start = dec_valid & dec_is_mul & ~stall & ~rst;
    end

    always_comb begin
        valid_d    = '0;
        rd_d[0]    = dec_rd;
        valid_d[0] = mul_start & (dec_rd != 5'd0);
        for (int i = 1; i < N; i++) begin
            valid_d[i] = valid_q[i-1];
            rd_d[i]    = rd_q[i-1];
        end
        inflight_d = '0;
        for (int i = 0; i < N; i++) begin
            inflight_d = inflight_d + {4'd0, valid_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            inflight_q <= '0;
            for (int i = 0; i < N; i++) rd_q[i] <= 5'd0;
        end else begin
            valid_q    <= valid_d;
            inflight_q <= inflight_d;
            for (int i = 0; i < N; i++) rd_q[i] <= rd_d[i];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sr_mul_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_sr_mul_scheduler
// Brief  : Self-checking bench: directed cycle tables plus random vs. model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sr_mul_scheduler;
    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       dec_valid, dec_is_mul, dec_wr;
    logic [4:0] dec_rs1, dec_rs2, dec_rd;
    logic [1:0] dec_rs_used;
    logic       stall, mul_start, wb_valid;
    logic [4:0] wb_rd, inflight;

    sr_mul_scheduler #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_is_mul(dec_is_mul), .dec_wr(dec_wr),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_rs_used(dec_rs_used),
        .stall(stall), .mul_start(mul_start), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .inflight(inflight)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, dv, mul, wr;
        logic [4:0] rs1, rs2, rd;
        logic [1:0] used;
        logic       stall, ms, wb;
        logic [4:0] wbrd, inf;
    } vec_t;

    typedef struct { logic [4:0] rd; int issue; } ent_t;

    vec_t tbl[$];
    ent_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    function automatic vec_t mk(logic r, logic dv, logic mul, logic wr,
                                logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                                logic [1:0] used, logic es, logic ems, logic ewb,
                                logic [4:0] ewbrd, logic [4:0] einf);
        vec_t v;
        v.rst = r; v.dv = dv; v.mul = mul; v.wr = wr;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.used = used;
        v.stall = es; v.ms = ems; v.wb = ewb; v.wbrd = ewbrd; v.inf = einf;
        return v;
    endfunction

    function automatic vec_t idle(logic ewb, logic [4:0] ewbrd, logic [4:0] einf);
        return mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, ewb, ewbrd, einf);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive, sample on the falling edge, then cross the rising edge.
    task automatic apply(input vec_t v, input string tag);
        rst = v.rst; dec_valid = v.dv; dec_is_mul = v.mul; dec_wr = v.wr;
        dec_rs1 = v.rs1; dec_rs2 = v.rs2; dec_rd = v.rd; dec_rs_used = v.used;
        @(negedge clk);
        chk({tag, ".stall"},     int'(stall),     int'(v.stall));
        chk({tag, ".mul_start"}, int'(mul_start), int'(v.ms));
        chk({tag, ".wb_valid"},  int'(wb_valid),  int'(v.wb));
        chk({tag, ".inflight"},  int'(inflight),  int'(v.inf));
        if (v.wb) chk({tag, ".wb_rd"}, int'(wb_rd), int'(v.wbrd));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reference: a MUL issued at cycle t with rd!=0 is live over cycles
    // t+1..t+N and writes back in cycle t+N.
    task automatic model(input vec_t s, output vec_t e);
        logic raw, waw, wbc;
        int   live;
        e = s; e.wb = 0; e.wbrd = 0; raw = 0; waw = 0; live = 0;
        foreach (sb[k]) begin
            if (sb[k].issue < cyc && cyc <= sb[k].issue + N) begin
                live++;
                if (s.used[0] && s.rs1 != 0 && s.rs1 == sb[k].rd) raw = 1;
                if (s.used[1] && s.rs2 != 0 && s.rs2 == sb[k].rd) raw = 1;
                if (s.wr && s.rd != 0 && s.rd == sb[k].rd) waw = 1;
                if (cyc == sb[k].issue + N) begin e.wb = 1; e.wbrd = sb[k].rd; end
            end
        end
        wbc     = s.wr && !s.mul && e.wb;
        e.stall = s.dv && (raw || waw || wbc);
        e.ms    = s.dv && s.mul && !e.stall && !s.rst;
        e.inf   = 5'(live);
    endtask

    task automatic model_commit(input vec_t e);
        int now = cyc - 1;
        if (e.rst) sb.delete();
        else begin
            if (e.ms && e.rd != 0) sb.push_back('{rd: e.rd, issue: now});
            for (int k = sb.size() - 1; k >= 0; k--)
                if (sb[k].issue + N <= now) sb.delete(k);
        end
    endtask

    initial begin
        vec_t s, e;

        // Reset, with a MUL presented during reset that must not launch.
        apply(mk(1, 1, 1, 1, 0, 0, 5, 2'b00, 0, 0, 0, 0, 0), "rst0");
        apply(mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0), "rst1");
        apply(idle(0, 0, 0), "post_rst");

        // RAW: MUL x5 then ADD x6,x5,x1 held until x5 retires.
        tbl.push_back(mk(0, 1, 1, 1, 1, 2, 5, 2'b11, 0, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 1, 0, 1, 5, 1, 6, 2'b11, 1, 0, i == 2, 5, 1));
        tbl.push_back(mk(0, 1, 0, 1, 5, 1, 6, 2'b11, 0, 0, 0, 0, 0));
        tbl.push_back(idle(0, 0, 0));
        // Three independent MULs back to back.
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 1, 2'b00, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 2, 2'b00, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 3, 2'b00, 0, 1, 0, 0, 2));
        tbl.push_back(idle(1, 1, 3));
        tbl.push_back(idle(1, 2, 2));
        tbl.push_back(idle(1, 3, 1));
        tbl.push_back(idle(0, 0, 0));
        // Writeback-port conflict: ADDI x9 in the cycle MUL x7 retires.
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 7, 2'b00, 0, 1, 0, 0, 0));
        tbl.push_back(idle(0, 0, 1));
        tbl.push_back(idle(0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, 9, 2'b01, 1, 0, 1, 7, 1));
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, 9, 2'b01, 0, 0, 0, 0, 0));
        // MUL x0 creates nothing.
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 6, 2'b11, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(idle(0, 0, 0));
        // WAW: ADDI x4 behind MUL x4.
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 4, 2'b00, 0, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 1, 0, 1, 2, 0, 4, 2'b01, 1, 0, i == 2, 4, 1));
        tbl.push_back(mk(0, 1, 0, 1, 2, 0, 4, 2'b01, 0, 0, 0, 0, 0));
        // MUL depending on MUL, then retire+load in the same cycle.
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 10, 2'b00, 0, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 1, 1, 1, 10, 0, 11, 2'b01, 1, 0, i == 2, 10, 1));
        tbl.push_back(mk(0, 1, 1, 1, 10, 0, 11, 2'b01, 0, 1, 0, 0, 0));
        tbl.push_back(idle(0, 0, 1));
        tbl.push_back(idle(0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 12, 2'b00, 0, 1, 1, 11, 1));
        tbl.push_back(idle(0, 0, 1));
        tbl.push_back(idle(0, 0, 1));
        tbl.push_back(idle(1, 12, 1));
        tbl.push_back(idle(0, 0, 0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

        // Reset mid-flight: MUL x8 must never write back.
        apply(mk(0, 1, 1, 1, 0, 0, 8, 2'b00, 0, 1, 0, 0, 0), "rstmid0");
        apply(mk(1, 1, 1, 1, 0, 0, 9, 2'b00, 0, 0, 0, 0, 1), "rstmid1");
        for (int i = 2; i <= 6; i++) apply(idle(0, 0, 0), $sformatf("rstmid%0d", i));

        // Randomised traffic against the issue-time model.
        sb.delete();
        for (int i = 0; i < 3000; i++) begin
            s.rst  = ($urandom_range(0, 49) == 0);
            s.dv   = ($urandom_range(0, 4) != 0);
            s.mul  = $urandom_range(0, 1);
            s.wr   = s.mul ? 1'b1 : 1'($urandom_range(0, 1));
            s.rs1  = 5'($urandom_range(0, 4));
            s.rs2  = 5'($urandom_range(0, 4));
            s.rd   = 5'($urandom_range(0, 4));
            s.used = 2'($urandom_range(0, 3));
            model(s, e);
            apply(e, "rand");
            model_commit(e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
